// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time writer for the instruction RAM of the single-cycle MIPS core.
// A big-endian program image arrives one byte at a time. Every four bytes are
// packed into a 32-bit instruction word. Each word is written into the RAM
// through its synchronous write port. The processor is held in reset until the
// whole image has been written.
//
// Ports
//   clk          clock; every register and the RAM write port use posedge clk
//   reset        asynchronous, active-high; restarts the load from word 0
//   start        single-cycle pulse; restarts a load from DONE or ERR only
//   in_valid     byte source holds a byte on in_data/in_last
//   in_data      image byte; the first byte of each word is instr[31:24]
//   in_last      marks in_data as the final byte of the image
//   in_ready     loader takes the presented byte on this cycle's edge
//   imem_we      RAM write enable; high only in WRITE
//   imem_wa      RAM word address (low bits of the word pointer)
//   imem_wd      RAM write data (the assembled word)
//   cpu_reset    processor reset; high until a load completes successfully
//   done         image loaded successfully
//   error        image malformed (partial final word, or overflow)
//   word_count   number of words written in the current load
//   dbg_state_o  current FSM state (0 LOAD, 1 WRITE, 2 DONE, 3 ERR)
//
// Handshake: a byte transfers on a rising clk edge exactly when in_valid and
// in_ready are both high during the preceding cycle. While in_ready is low the
// source keeps in_valid, in_data and in_last stable, so no byte is ever lost.
// A byte offered during the WRITE cycle transfers in the next LOAD cycle.
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_wa,
    output logic [31:0]           imem_wd,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    // The word pointer is one bit wider than the RAM address. This lets
    // word_count report a completely full RAM (2^ADDR_WIDTH words).
    localparam logic [ADDR_WIDTH:0] WP_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0] WP_ONE  = 1;

    state_t                state_q;
    logic [1:0]            bc_q;          // bytes already packed into sr_q
    logic [31:0]           sr_q;          // word assembly shift register
    logic [ADDR_WIDTH:0]   wp_q;          // next RAM word to write
    logic                  last_seen_q;   // the word in sr_q ends the image

    logic                  accept;

    assign accept = in_valid & in_ready;

    // All outputs are decoded directly from the state register. in_ready is
    // also masked by reset, so no byte can be taken while reset is asserted.
    assign in_ready    = (state_q == S_LOAD) & ~reset;
    assign imem_we     = (state_q == S_WRITE);
    assign imem_wa     = wp_q[ADDR_WIDTH-1:0];
    assign imem_wd     = sr_q;
    assign cpu_reset   = (state_q != S_DONE);
    assign done        = (state_q == S_DONE);
    assign error       = (state_q == S_ERR);
    assign word_count  = wp_q;
    assign dbg_state_o = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_LOAD;
            bc_q        <= 2'd0;
            sr_q        <= 32'd0;
            wp_q        <= '0;
            last_seen_q <= 1'b0;
        end else begin
            // accept can only be high in LOAD, so the shift is independent
            // of the state decode below.
            if (accept) begin
                sr_q <= {sr_q[23:0], in_data};
                bc_q <= bc_q + 2'd1;
            end

            case (state_q)
                S_LOAD: begin
                    if (accept) begin
                        if (bc_q == 2'd3) begin
                            state_q     <= S_WRITE;
                            last_seen_q <= in_last;
                        end else if (in_last) begin
                            // Image ended inside a word; nothing is written.
                            state_q <= S_ERR;
                        end
                    end
                end

                S_WRITE: begin
                    wp_q <= wp_q + WP_ONE;
                    bc_q <= 2'd0;
                    // A last word landing in the final slot is a clean finish.
                    // Only a non-final word there overflows the RAM. That
                    // word is still written before the error is raised.
                    if (last_seen_q) begin
                        state_q <= S_DONE;
                    end else if (wp_q == WP_LAST) begin
                        state_q <= S_ERR;
                    end else begin
                        state_q <= S_LOAD;
                    end
                end

                S_DONE, S_ERR: begin
                    if (start) begin
                        wp_q        <= '0;
                        bc_q        <= 2'd0;
                        last_seen_q <= 1'b0;
                        state_q     <= S_LOAD;
                    end
                end

                default: state_q <= S_LOAD;
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the single-cycle MIPS instruction memory. It accepts a program image as a big-endian byte stream over a valid/ready handshake and assembles 32-bit words. It writes each word into the instruction RAM through a new synchronous write port and holds the processor in reset until the whole image is loaded. It sits between the host/UART byte source and `imem`. It drives `top`'s processor reset in place of the external reset.

## Interface
- `ADDR_WIDTH`, 6: instruction RAM word-address width; image capacity is 2^ADDR_WIDTH words.
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `start`  in  1  single-cycle pulse; restarts a load from DONE or ERR, ignored in other states
- `in_valid`  in  1  byte source has a byte
- `in_data`  in  8  image byte; first byte of each word is instr[31:24]
- `in_last`  in  1  qualifies `in_data` as the final byte of the image
- `in_ready`  out  1  loader accepts a byte this cycle
- `imem_we`  out  1  instruction RAM write enable (RAM writes on posedge clk)
- `imem_wa`  out  ADDR_WIDTH  instruction RAM word address
- `imem_wd`  out  32  instruction word to write
- `cpu_reset`  out  1  processor reset; high until the load completes
- `done`  out  1  image loaded successfully
- `error`  out  1  image malformed (partial word or overflow)
- `word_count`  out  ADDR_WIDTH+1  words written in the current load

## Operation
- The FSM has four states: LOAD, WRITE, DONE, ERR. Reset enters LOAD.
- Internal state:
  - byte counter `bc` (2 bits)
  - 32-bit shift register `sr`
  - word pointer `wp` (ADDR_WIDTH+1 bits)
  - `last_seen` flag
- A byte is accepted when `in_valid & in_ready`.
- On accept: `sr <= {sr[23:0], in_data}` and `bc <= bc+1`.
- LOAD:
  - `in_ready` = 1.
  - An accept with `bc==3` goes to WRITE and latches `last_seen <= in_last`.
  - An accept with `bc!=3` and `in_last=1` goes to ERR (partial word); no write is issued.
- WRITE:
  - `in_ready` = 0.
  - `imem_we` = 1, `imem_wa = wp[ADDR_WIDTH-1:0]`, `imem_wd = sr`.
  - `wp <= wp+1` and `bc <= 0`.
  - Next state:
    - DONE if `last_seen`.
    - Else ERR if `wp == 2^ADDR_WIDTH-1` (overflow; the write is still performed).
    - Else LOAD.
- DONE:
  - `in_ready` = 0, `done` = 1.
  - `start` clears `wp`, `bc` and `last_seen`, then goes to LOAD.
- ERR:
  - `in_ready` = 0, `error` = 1.
  - `start` behaves the same as in DONE.
- Outputs decoded from the state register:
  - `cpu_reset = (state != DONE)`.
  - `word_count = wp`.
  - `imem_we` is 1 only in WRITE.
  - `in_ready = (state==LOAD) & ~reset`.
- Bytes are never dropped. A byte presented while `in_ready`=0 is held by the source and accepted later.
- A byte presented in the WRITE cycle is accepted in the following LOAD cycle.
- `imem` gains write port inputs (`we`, `wa`, `wd`) clocked by `clk`. The read path is unchanged.
- In `top`, the `flopr` PC register receives `reset | cpu_reset`.

## Timing
- Reset values:
  - state LOAD
  - `in_ready` 0 while `reset` is high, 1 after release
  - `imem_we` 0, `imem_wa` 0, `imem_wd` 0
  - `cpu_reset` 1, `done` 0, `error` 0, `word_count` 0
- Word latency: the 4th byte is accepted at edge N, `imem_we` is high for the cycle N..N+1, and the RAM is written at edge N+1.
- Throughput: at most 4 bytes per 5 cycles.
- End of load: the final word is written at edge N+1. `done` rises and `cpu_reset` falls after the same edge N+1. The processor fetches PC=0 at edge N+2.
- ERR on a partial word is entered at the edge that accepts the offending byte.
- ERR on overflow is entered at the edge that completes the write of address 2^ADDR_WIDTH-1.
- Reset asserted mid-load:
  - Immediately clears all state and drops `imem_we`.
  - Already-written RAM words are untouched.
  - The load restarts from word 0.
- `start` while in LOAD or WRITE has no effect.

## Test plan
- Reset values: assert `reset` for 2 cycles -> `cpu_reset`=1, `in_ready`=0, `imem_we`=0, `done`=0, `error`=0, `word_count`=0. After release, `in_ready`=1.
- Two-word image: bytes 20 02 00 05 20 03 00 0C streamed back-to-back, `in_last` on byte 8:
  - RAM[0]=32'h20020005 and RAM[1]=32'h2003000C, each written one cycle after its 4th byte.
  - `done`=1, `word_count`=2; `cpu_reset` falls after the second write.
  - The processor then executes from PC 0.
- Backpressure and bubbles: `in_valid` toggled randomly, and a byte held valid through the WRITE cycle -> the byte is consumed exactly once, in the next LOAD cycle. RAM contents match the stream.
- Partial word: 3 bytes with `in_last` on the 3rd -> `error`=1 at that edge, no `imem_we` pulse, `cpu_reset` stays 1, `word_count`=0.
- Capacity:
  - 64 words with `in_last` on byte 256 -> `done`=1, `word_count`=64.
  - 64 words without `in_last` -> 64 writes then `error`=1, `word_count`=64.
- Restart and mid-load reset:
  - `start` in DONE -> LOAD, `word_count`=0, `cpu_reset`=1; a reload of a 1-word image gives `done`=1, `word_count`=1.
  - `reset` after byte 6 of a load -> all outputs return to their reset values; a subsequent full stream loads correctly from address 0.
